// File: rtl/fetch_pc_select.sv
// Fetch PC selection and F pipeline register for the Y86-64 pipeline.
// Redirects on jXX mispredict (M) and ret (W); bubbles fetch while a ret is in flight or after halt.
module fetch_pc_select #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned RET_BUBBLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] predPC,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic        stall_F,
    output logic [63:0] f_pc,
    output logic [63:0] F_predPC,
    output logic        fetch_bubble,
    output logic        mispredict,
    output logic        ret_pending,
    output logic        halted
);

    localparam logic [3:0] IHalt = 4'h0;
    localparam logic [3:0] IJxx  = 4'h7;
    localparam logic [3:0] IRet  = 4'h9;
    localparam logic [1:0] RetCnt = RET_BUBBLES[1:0];

    typedef enum logic [1:0] {StRun, StRetWait, StHalt} state_e;

    state_e      state_q, state_d;
    logic [63:0] pred_pc_q, pred_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        mis, retw;

    assign mis  = (M_icode == IJxx) && !M_cnd;
    assign retw = (W_icode == IRet);

    assign F_predPC    = pred_pc_q;
    assign ret_pending = (state_q == StRetWait);
    assign halted      = (state_q == StHalt);

    // Reset overrides the combinational redirect outputs.
    always_comb begin
        f_pc         = RESET_PC;
        mispredict   = 1'b0;
        fetch_bubble = 1'b0;
        if (rst_n) begin
            mispredict = mis;
            if (mis) begin
                f_pc = M_valA;
            end else if (retw) begin
                f_pc = W_valM;
            end else begin
                f_pc = pred_pc_q;
            end
            case (state_q)
                StRetWait: fetch_bubble = !mis && !(retw && (cnt_q == 2'd0));
                StHalt:    fetch_bubble = !mis;
                default:   fetch_bubble = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pred_pc_d = pred_pc_q;
        cnt_d     = cnt_q;
        case (state_q)
            StRun: begin
                if (mis) begin
                    pred_pc_d = predPC;
                end else if (stall_F) begin
                    pred_pc_d = pred_pc_q;
                end else if (f_icode == IRet) begin
                    cnt_d   = RetCnt;
                    state_d = StRetWait;
                end else if (f_icode == IHalt) begin
                    state_d = StHalt;
                end else begin
                    pred_pc_d = predPC;
                end
            end
            StRetWait: begin
                cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
                // An early ret in W (cnt still nonzero) is not ours yet; keep bubbling.
                if (mis || (retw && (cnt_q == 2'd0))) begin
                    pred_pc_d = predPC;
                    state_d   = StRun;
                end
            end
            StHalt: begin
                if (mis) begin
                    pred_pc_d = predPC;
                    state_d   = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StRun;
            pred_pc_q <= RESET_PC;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_select.sv
// Directed self-checking bench for fetch_pc_select (RESET_PC = 0x100, RET_BUBBLES = 3).
module tb_fetch_pc_select;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] predPC;
    logic [3:0]  f_icode;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic        stall_F;
    logic [63:0] f_pc;
    logic [63:0] F_predPC;
    logic        fetch_bubble;
    logic        mispredict;
    logic        ret_pending;
    logic        halted;

    int passed = 0;
    int total  = 0;

    fetch_pc_select #(
        .RESET_PC   (64'h100),
        .RET_BUBBLES(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .predPC      (predPC),
        .f_icode     (f_icode),
        .M_icode     (M_icode),
        .M_cnd       (M_cnd),
        .M_valA      (M_valA),
        .W_icode     (W_icode),
        .W_valM      (W_valM),
        .stall_F     (stall_F),
        .f_pc        (f_pc),
        .F_predPC    (F_predPC),
        .fetch_bubble(fetch_bubble),
        .mispredict  (mispredict),
        .ret_pending (ret_pending),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; f_icode = 4'h1; predPC = 64'h0; stall_F = 1'b0;
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'hDEAD; W_icode = 4'h1; W_valM = 64'h0;
        #1;
        total++; if (f_pc !== 64'h100) $display("FAIL rst_fpc_forced got %h want %h", f_pc, 64'h100); else passed++;
        total++; if (mispredict !== 1'b0) $display("FAIL rst_mis_forced got %b want 0", mispredict); else passed++;
        tick(); tick();
        M_icode = 4'h1;
        total++; if (F_predPC !== 64'h100) $display("FAIL rst_predpc got %h want %h", F_predPC, 64'h100); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL rst_halted got %b want 0", halted); else passed++;
        total++; if (ret_pending !== 1'b0) $display("FAIL rst_retpend got %b want 0", ret_pending); else passed++;
        rst_n = 1'b1; #1;
        total++; if (f_pc !== 64'h100) $display("FAIL rst_fpc got %h want %h", f_pc, 64'h100); else passed++;
        total++; if (fetch_bubble !== 1'b0) $display("FAIL rst_bubble got %b want 0", fetch_bubble); else passed++;
    endtask

    task automatic test_straight();
        f_icode = 4'h6; predPC = 64'h10A; #1;
        tick();
        total++; if (F_predPC !== 64'h10A) $display("FAIL line_predpc got %h want %h", F_predPC, 64'h10A); else passed++;
        total++; if (f_pc !== 64'h10A) $display("FAIL line_fpc got %h want %h", f_pc, 64'h10A); else passed++;
        total++; if (fetch_bubble !== 1'b0) $display("FAIL line_bubble got %b want 0", fetch_bubble); else passed++;
    endtask

    task automatic test_mispredict();
        stall_F = 1'b1; M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h2A0; predPC = 64'h2A8; #1;
        total++; if (f_pc !== 64'h2A0) $display("FAIL mis_fpc got %h want %h", f_pc, 64'h2A0); else passed++;
        total++; if (mispredict !== 1'b1) $display("FAIL mis_flag got %b want 1", mispredict); else passed++;
        tick();
        total++; if (F_predPC !== 64'h2A8) $display("FAIL mis_predpc got %h want %h", F_predPC, 64'h2A8); else passed++;
        M_cnd = 1'b1; #1;
        total++; if (mispredict !== 1'b0) $display("FAIL taken_nomis got %b want 0", mispredict); else passed++;
        // Stall with a ret fetched: hold and stay in RUN.
        M_icode = 4'h1; f_icode = 4'h9; predPC = 64'h300;
        tick();
        total++; if (F_predPC !== 64'h2A8) $display("FAIL stall_hold got %h want %h", F_predPC, 64'h2A8); else passed++;
        total++; if (ret_pending !== 1'b0) $display("FAIL stall_noret got %b want 0", ret_pending); else passed++;
        stall_F = 1'b0; f_icode = 4'h6;
    endtask

    task automatic test_ret();
        f_icode = 4'h9; predPC = 64'h2B0;
        tick();  // t+1
        f_icode = 4'h1; #1;
        total++; if (ret_pending !== 1'b1) $display("FAIL ret_pend1 got %b want 1", ret_pending); else passed++;
        total++; if (fetch_bubble !== 1'b1) $display("FAIL ret_bub1 got %b want 1", fetch_bubble); else passed++;
        total++; if (F_predPC !== 64'h2A8) $display("FAIL ret_hold got %h want %h", F_predPC, 64'h2A8); else passed++;
        tick();  // t+2, early ret in W
        W_icode = 4'h9; W_valM = 64'h111; #1;
        total++; if (fetch_bubble !== 1'b1) $display("FAIL ret_bub2 got %b want 1", fetch_bubble); else passed++;
        total++; if (f_pc !== 64'h111) $display("FAIL ret_early_fpc got %h want %h", f_pc, 64'h111); else passed++;
        tick();  // t+3
        W_icode = 4'h1; #1;
        total++; if (ret_pending !== 1'b1) $display("FAIL ret_pend3 got %b want 1", ret_pending); else passed++;
        total++; if (fetch_bubble !== 1'b1) $display("FAIL ret_bub3 got %b want 1", fetch_bubble); else passed++;
        tick();  // t+4
        W_icode = 4'h9; W_valM = 64'h400; predPC = 64'h40A; #1;
        total++; if (f_pc !== 64'h400) $display("FAIL ret_fpc got %h want %h", f_pc, 64'h400); else passed++;
        total++; if (fetch_bubble !== 1'b0) $display("FAIL ret_bub4 got %b want 0", fetch_bubble); else passed++;
        tick();  // t+5
        W_icode = 4'h1; f_icode = 4'h6; #1;
        total++; if (ret_pending !== 1'b0) $display("FAIL ret_run got %b want 0", ret_pending); else passed++;
        total++; if (F_predPC !== 64'h40A) $display("FAIL ret_predpc got %h want %h", F_predPC, 64'h40A); else passed++;
    endtask

    task automatic test_wrong_path_ret();
        f_icode = 4'h9; predPC = 64'h410;
        tick();
        f_icode = 4'h1;
        tick();  // t+2
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h88; predPC = 64'h90; #1;
        total++; if (f_pc !== 64'h88) $display("FAIL wp_fpc got %h want %h", f_pc, 64'h88); else passed++;
        total++; if (fetch_bubble !== 1'b0) $display("FAIL wp_bubble got %b want 0", fetch_bubble); else passed++;
        tick();
        M_icode = 4'h1; f_icode = 4'h6; #1;
        total++; if (ret_pending !== 1'b0) $display("FAIL wp_retpend got %b want 0", ret_pending); else passed++;
        total++; if (F_predPC !== 64'h90) $display("FAIL wp_predpc got %h want %h", F_predPC, 64'h90); else passed++;
    endtask

    task automatic test_halt();
        f_icode = 4'h0; predPC = 64'h98;
        tick();
        f_icode = 4'h1; predPC = 64'hAA; #1;
        total++; if (halted !== 1'b1) $display("FAIL halt_state got %b want 1", halted); else passed++;
        total++; if (fetch_bubble !== 1'b1) $display("FAIL halt_bubble got %b want 1", fetch_bubble); else passed++;
        tick(); tick();
        W_icode = 4'h9; W_valM = 64'h77; #1;
        total++; if (f_pc !== 64'h77) $display("FAIL halt_retw_fpc got %h want %h", f_pc, 64'h77); else passed++;
        tick();
        W_icode = 4'h1; #1;
        total++; if (halted !== 1'b1) $display("FAIL halt_stays got %b want 1", halted); else passed++;
        total++; if (F_predPC !== 64'h90) $display("FAIL halt_hold got %h want %h", F_predPC, 64'h90); else passed++;
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h50; predPC = 64'h58; #1;
        total++; if (f_pc !== 64'h50) $display("FAIL halt_mis_fpc got %h want %h", f_pc, 64'h50); else passed++;
        tick();
        M_icode = 4'h1; #1;
        total++; if (halted !== 1'b0) $display("FAIL halt_exit got %b want 0", halted); else passed++;
        total++; if (F_predPC !== 64'h58) $display("FAIL halt_exit_pc got %h want %h", F_predPC, 64'h58); else passed++;
        // Reset out of HALT.
        f_icode = 4'h0;
        tick();
        rst_n = 1'b0; f_icode = 4'h1;
        tick();
        total++; if (halted !== 1'b0) $display("FAIL halt_rst got %b want 0", halted); else passed++;
        total++; if (F_predPC !== 64'h100) $display("FAIL halt_rst_pc got %h want %h", F_predPC, 64'h100); else passed++;
    endtask

    task automatic test_reset_in_ret();
        rst_n = 1'b1; f_icode = 4'h9;
        tick();
        f_icode = 4'h1; #1;
        total++; if (ret_pending !== 1'b1) $display("FAIL rret_enter got %b want 1", ret_pending); else passed++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; #1;
        total++; if (ret_pending !== 1'b0) $display("FAIL rret_clear got %b want 0", ret_pending); else passed++;
        total++; if (fetch_bubble !== 1'b0) $display("FAIL rret_bubble got %b want 0", fetch_bubble); else passed++;
    endtask

    initial begin
        test_reset();
        test_straight();
        test_mispredict();
        test_ret();
        test_wrong_path_ret();
        test_halt();
        test_reset_in_ret();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
